// File: rtl/noise_arb.sv
// rtl/noise_arb.sv - round-robin arbiter sharing one 23-bit noise LFSR among voices
module noise_arb #(
  parameter int NUM_REQ = 4,
  parameter int STEPS   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [7:0]         dout,
  input  logic               seed_we,
  input  logic [22:0]        seed,
  output logic               busy
);

  localparam logic [22:0] SEED_DEF = 23'h37242B;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  state_t          state, state_n;
  logic [22:0]     s, s_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   win, win_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [NUM_REQ-1:0] ack_n;
  logic [7:0]      dout_n;
  logic            busy_n;
  logic            found;
  logic [IW-1:0]   grant;
  logic [22:0]     s_step;
  int              idx;

  function automatic logic [22:0] lfsr_step(input logic [22:0] v);
    return (v == 23'd0) ? SEED_DEF : {v[21:0], v[22] ^ v[17]};
  endfunction

  function automatic logic [7:0] taps(input logic [22:0] v);
    return {v[22], v[20], v[16], v[13], v[11], v[7], v[4], v[2]};
  endfunction

  assign s_step = lfsr_step(s);

  // First set request at or after ptr, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    grant = ptr;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        grant = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    cnt_n   = cnt;
    win_n   = win;
    ptr_n   = ptr;
    ack_n   = ack;
    dout_n  = dout;
    case (state)
      IDLE: begin
        if (seed_we) begin
          s_n = (seed == 23'd0) ? SEED_DEF : seed;
        end else if (found) begin
          win_n   = grant;
          cnt_n   = CW'(STEPS - 1);
          state_n = STEP;
        end
      end
      STEP: begin
        s_n = s_step;
        if (cnt == '0) begin
          state_n    = DONE;
          dout_n     = taps(s_step);
          ack_n      = '0;
          ack_n[win] = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE: begin
        ack_n   = '0;
        ptr_n   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        state_n = IDLE;
      end
      default: begin
        ack_n   = '0;
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s     <= SEED_DEF;
      cnt   <= '0;
      win   <= '0;
      ptr   <= '0;
      ack   <= '0;
      dout  <= 8'h00;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      s     <= s_n;
      cnt   <= cnt_n;
      win   <= win_n;
      ptr   <= ptr_n;
      ack   <= ack_n;
      dout  <= dout_n;
      busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_noise_arb.sv
// tb/tb_noise_arb.sv - self-checking bench for noise_arb with LFSR scoreboard
`timescale 1ns/1ps
module tb_noise_arb;

  localparam int NUM_REQ = 4;
  localparam int STEPS   = 8;
  localparam logic [22:0] SEED_DEF = 23'h37242B;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   ack;
  logic [7:0]   dout;
  logic         seed_we;
  logic [22:0]  seed;
  logic         busy;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] dout;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [3:0] req;
    int         win;
  } vec_t;
  vec_t vecs[16];

  logic [22:0] s_m;

  noise_arb #(.NUM_REQ(NUM_REQ), .STEPS(STEPS)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .dout(dout),
    .seed_we(seed_we), .seed(seed), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] m_step(input logic [22:0] v);
    return (v == 23'd0) ? SEED_DEF : {v[21:0], v[22] ^ v[17]};
  endfunction

  function automatic logic [7:0] m_taps(input logic [22:0] v);
    return {v[22], v[20], v[16], v[13], v[11], v[7], v[4], v[2]};
  endfunction

  task automatic push_exp(input int w);
    exp_t e;
    for (int i = 0; i < STEPS; i++) s_m = m_step(s_m);
    e.ack  = 4'b0001 << w;
    e.dout = m_taps(s_m);
    exp_q.push_back(e);
  endtask

  // Scoreboard: every ack pulse must match the oldest queued grant.
  always @(negedge clk) begin
    if (!rst && ack != 4'b0000) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_ack: got ack=%b dout=0x%0h with nothing queued", ack, dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_ack", 32'(ack), 32'(e.ack));
        chk("sb_dout", 32'(dout), 32'(e.dout));
      end
    end
  end

  task automatic wait_ack(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end while (ack == 4'b0000 && lat < 100);
    if (ack == 4'b0000) begin
      tests++;
      errors++;
      $display("FAIL ack_timeout: got no ack within %0d cycles, required one", lat);
    end
  endtask

  task automatic run_req(input logic [3:0] r, input int w, output int lat);
    int bc;
    push_exp(w);
    req = r;
    wait_ack(lat, bc);
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic load_seed(input logic [22:0] v);
    seed_we = 1'b1;
    seed    = v;
    @(negedge clk);
    seed_we = 1'b0;
    seed    = 23'h5A5A5A;
    s_m     = (v == 23'd0) ? SEED_DEF : v;
  endtask

  initial begin
    int lat, bc, n_ack;
    int ack_cyc[5];

    vecs[0]  = '{4'b1111, 1};  vecs[1]  = '{4'b1111, 2};
    vecs[2]  = '{4'b1111, 3};  vecs[3]  = '{4'b0001, 0};
    vecs[4]  = '{4'b1010, 1};  vecs[5]  = '{4'b1001, 3};
    vecs[6]  = '{4'b0110, 1};  vecs[7]  = '{4'b0110, 2};
    vecs[8]  = '{4'b0011, 0};  vecs[9]  = '{4'b1010, 1};
    vecs[10] = '{4'b1010, 3};  vecs[11] = '{4'b0100, 2};
    vecs[12] = '{4'b1100, 3};  vecs[13] = '{4'b1110, 1};
    vecs[14] = '{4'b0011, 0};  vecs[15] = '{4'b1000, 3};

    rst = 1'b1; req = 4'b0000; seed_we = 1'b0; seed = 23'd0;
    s_m = SEED_DEF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    run_req(4'b0001, 0, lat);
    chk("first_latency", 32'(lat), 32'd9);

    // Reset in the middle of STEP discards the grant.
    req = 4'b0010;
    repeat (4) @(negedge clk);
    chk("busy_mid_step", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ack", 32'(ack), 32'd0);
    chk("async_rst_dout", 32'(dout), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s_m = SEED_DEF;
    push_exp(1);
    wait_ack(lat, bc);
    chk("post_reset_latency", 32'(lat), 32'd9);
    req = 4'b0000;
    @(negedge clk);

    // Round robin with all requests held, from ptr=0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_m = SEED_DEF;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    req = 4'b1111;
    n_ack = 0;
    for (int c = 1; c <= 100 && n_ack < 5; c++) begin
      @(negedge clk);
      if (ack != 4'b0000) begin
        ack_cyc[n_ack] = c;
        n_ack++;
      end
    end
    req = 4'b0000;
    @(negedge clk);
    chk("rr_ack_count", 32'(n_ack), 32'd5);
    chk("rr_first_latency", 32'(ack_cyc[0]), 32'd9);
    for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd10);

    run_req(4'b0101, 2, lat);

    // Known-answer: seed 1 walks a single bit up the register.
    load_seed(23'h000001);
    run_req(4'b0001, 0, lat);
    chk("kat_dout0", 32'(dout), 32'h00);
    run_req(4'b0001, 0, lat);
    chk("kat_dout1", 32'(dout), 32'h20);

    // Seed and request in the same IDLE cycle: seed wins, grant one cycle later.
    seed_we = 1'b1;
    seed    = 23'h2A5F31;
    req     = 4'b0100;
    s_m     = 23'h2A5F31;
    push_exp(2);
    @(negedge clk);
    seed_we = 1'b0;
    wait_ack(lat, bc);
    chk("seed_req_latency", 32'(lat + 1), 32'd10);
    req = 4'b0000;
    @(negedge clk);

    // Seed during STEP is ignored.
    push_exp(3);
    req = 4'b1000;
    repeat (3) @(negedge clk);
    seed_we = 1'b1;
    seed    = 23'h000123;
    @(negedge clk);
    seed_we = 1'b0;
    wait_ack(lat, bc);
    req = 4'b0000;
    @(negedge clk);

    // Winner drops its request mid-STEP while another voice rises.
    push_exp(0);
    req = 4'b0001;
    lat = 0;
    bc  = 0;
    repeat (3) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
    req = 4'b0010;
    do begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end while (ack == 4'b0000 && lat < 100);
    chk("stable_ack", 32'(ack), 32'b0001);
    chk("stable_busy_cycles", 32'(bc), 32'(STEPS + 1));
    req = 4'b0000;
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);

    // Zero seed restores the reset sequence; mixed request patterns from ptr=1.
    load_seed(23'd0);
    for (int i = 0; i < 16; i++) begin
      run_req(vecs[i].req, vecs[i].win, lat);
      chk("vec_latency", 32'(lat), 32'd9);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
